instr_fetch_sequencer: RTL



---
 rtl/instr_fetch_sequencer_if.sv | 46 ++++
 rtl/instr_fetch_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// Handshake and data signals between the fetch sequencer and its
// neighbours: request side, program-memory side and serial output.
interface instr_fetch_sequencer_if;
    logic        fetch_req;
    logic [15:0] pc;
    logic [7:0]  addr_out;
    logic        addr_valid;
    logic        addr_ready;
    logic [7:0]  mem_byte;
    logic        mem_valid;
    logic [7:0]  serial_out;
    logic        data_ready;
    logic        busy;
    logic        fetch_done;
    logic        timeout_err;

    modport master (
        output fetch_req,
        output pc,
        output addr_ready,
        output mem_byte,
        output mem_valid,
        input  addr_out,
        input  addr_valid,
        input  serial_out,
        input  data_ready,
        input  busy,
        input  fetch_done,
        input  timeout_err
    );

    modport slave (
        input  fetch_req,
        input  pc,
        input  addr_ready,
        input  mem_byte,
        input  mem_valid,
        output addr_out,
        output addr_valid,
        output serial_out,
        output data_ready,
        output busy,
        output fetch_done,
        output timeout_err
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Byte-serial instruction fetch: sends the PC as two address bytes, then
// forwards the 2- or 4-byte instruction one byte per data_ready strobe.
module instr_fetch_sequencer #(
    parameter logic [2:0]  OPC_I   = 3'd1,
    parameter logic [2:0]  OPC_M   = 3'd4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    instr_fetch_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        RECV
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] wd_q;
    logic [1:0]  cnt_q;
    logic        len4_q;
    logic [7:0]  addr_out_q;
    logic        addr_valid_q;
    logic [7:0]  serial_q;
    logic        data_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        hs_d;
    logic        long_d;
    logic        last_d;
    logic        expire_d;
    logic [15:0] wd_d;

    // Byte 0 is never the last one, so a stale len4_q is harmless there.
    always_comb begin
        hs_d     = addr_valid_q & bus.addr_ready;
        long_d   = (bus.mem_byte[2:0] == OPC_I) ||
                   (bus.mem_byte[2:0] == OPC_M);
        last_d   = len4_q ? (cnt_q == 2'd3) : (cnt_q == 2'd1);
        expire_d = (wd_q == WD_LAST);
        wd_d     = wd_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            wd_q         <= '0;
            cnt_q        <= '0;
            len4_q       <= 1'b0;
            addr_out_q   <= '0;
            addr_valid_q <= 1'b0;
            serial_q     <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.fetch_req) begin
                        state_q      <= ADDR_LO;
                        pc_q         <= bus.pc;
                        err_q        <= 1'b0;
                        addr_out_q   <= bus.pc[7:0];
                        addr_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        wd_q         <= '0;
                    end
                end
                ADDR_LO: begin
                    if (hs_d) begin
                        state_q    <= ADDR_HI;
                        addr_out_q <= pc_q[15:8];
                        wd_q       <= '0;
                    end else if (expire_d) begin
                        state_q      <= IDLE;
                        addr_out_q   <= '0;
                        addr_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        err_q        <= 1'b1;
                        wd_q         <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                ADDR_HI: begin
                    if (hs_d) begin
                        state_q      <= RECV;
                        addr_out_q   <= '0;
                        addr_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        len4_q       <= 1'b0;
                        wd_q         <= '0;
                    end else if (expire_d) begin
                        state_q      <= IDLE;
                        addr_out_q   <= '0;
                        addr_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        err_q        <= 1'b1;
                        wd_q         <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                RECV: begin
                    if (bus.mem_valid) begin
                        serial_q     <= bus.mem_byte;
                        data_ready_q <= 1'b1;
                        cnt_q        <= cnt_q + 2'd1;
                        wd_q         <= '0;
                        if (cnt_q == 2'd0) begin
                            len4_q <= long_d;
                        end
                        if (last_d) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (expire_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_out    = addr_out_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.serial_out  = serial_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.busy        = busy_q;
    assign bus.fetch_done  = done_q;
    assign bus.timeout_err = err_q;

endmodule
